// File: rtl/dot_pkg.sv
// Shared definitions for the dot-position update path: default geometry,
// beat hold length, sequencer state encoding and the coordinate clamp helper.
package dot_pkg;

    localparam int NUM_DOTS    = 10;
    localparam int HOLD_CYCLES = 4;
    localparam int WIDTH       = 640;
    localparam int HEIGHT      = 480;
    localparam int X_W         = 10;
    localparam int Y_W         = 9;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SCAN   = 3'd1,
        ST_SEND_X = 3'd2,
        ST_SEND_Y = 3'd3,
        ST_DONE   = 3'd4
    } dot_state_e;

    // Saturate a full-width coordinate to lim-1; callers keep the low bits.
    function automatic logic [15:0] clamp_coord(input logic [31:0] v, input logic [31:0] lim);
        return (v >= lim) ? 16'(lim - 32'd1) : v[15:0];
    endfunction

endpackage

// File: rtl/dot_update_sequencer_if.sv
// Processor-side write/frame signals plus the VGA dot-port beat outputs.
// The sequencer is the slave of the processor and drives the dot port.
interface dot_update_sequencer_if;
    logic        procWren;
    logic [31:0] procID;
    logic [31:0] procX;
    logic [31:0] procY;
    logic        screenEnd;
    logic        dotWren;
    logic        is_Yloc;
    logic [31:0] dotID;
    logic [31:0] dotLoc;
    logic        busy;
    logic        frameDone;

    modport master (
        output procWren, procID, procX, procY, screenEnd,
        input  dotWren, is_Yloc, dotID, dotLoc, busy, frameDone
    );

    modport slave (
        input  procWren, procID, procX, procY, screenEnd,
        output dotWren, is_Yloc, dotID, dotLoc, busy, frameDone
    );
endinterface

// File: rtl/dot_shadow_ram.sv
// Shadow copy of every dot position with a per-entry dirty flag.
// One clamped write port from the processor, one combinational read port
// addressed by the sequencer; a processor write beats a same-cycle clear.
module dot_shadow_ram #(
    parameter int N      = dot_pkg::NUM_DOTS,
    parameter int IDW    = $clog2(dot_pkg::NUM_DOTS),
    parameter int WIDTH  = dot_pkg::WIDTH,
    parameter int HEIGHT = dot_pkg::HEIGHT
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en_i,
    input  logic [31:0]              wr_id_i,
    input  logic [31:0]              wr_x_i,
    input  logic [31:0]              wr_y_i,
    input  logic [IDW-1:0]           rd_idx_i,
    input  logic                     clr_i,
    output logic [dot_pkg::X_W-1:0]  rd_x_o,
    output logic [dot_pkg::Y_W-1:0]  rd_y_o,
    output logic                     rd_dirty_o
);
    import dot_pkg::*;

    logic [X_W-1:0] x_q [N];
    logic [Y_W-1:0] y_q [N];
    logic [N-1:0]   dirty_q;
    logic [N-1:0]   dirty_d;
    logic           wr_hit_s;
    logic [X_W-1:0] x_clamp_s;
    logic [Y_W-1:0] y_clamp_s;

    assign wr_hit_s  = wr_en_i && (wr_id_i < 32'(N));
    assign x_clamp_s = X_W'(clamp_coord(wr_x_i, 32'(WIDTH)));
    assign y_clamp_s = Y_W'(clamp_coord(wr_y_i, 32'(HEIGHT)));

    assign rd_x_o     = x_q[rd_idx_i];
    assign rd_y_o     = y_q[rd_idx_i];
    assign rd_dirty_o = dirty_q[rd_idx_i];

    // Dirty update: new processor write sets, sequencer latch clears, write wins.
    always_comb begin
        dirty_d = dirty_q;
        for (int i = 0; i < N; i++) begin
            if (wr_hit_s && (wr_id_i == 32'(i))) begin
                dirty_d[i] = 1'b1;
            end else if (clr_i && (rd_idx_i == IDW'(i))) begin
                dirty_d[i] = 1'b0;
            end else begin
                dirty_d[i] = dirty_q[i];
            end
        end
    end

    // Coordinate storage and dirty mask registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dirty_q <= '0;
            for (int i = 0; i < N; i++) begin
                x_q[i] <= '0;
                y_q[i] <= '0;
            end
        end else begin
            dirty_q <= dirty_d;
            for (int i = 0; i < N; i++) begin
                if (wr_hit_s && (wr_id_i == 32'(i))) begin
                    x_q[i] <= x_clamp_s;
                    y_q[i] <= y_clamp_s;
                end
            end
        end
    end
endmodule

// File: rtl/dot_update_sequencer.sv
// Frame-boundary sweeper: on each screenEnd rise it walks the shadow buffer
// and emits an X beat then a Y beat per dirty dot, each held HOLD_CYCLES
// clocks so the slower pixel-clock domain samples it. One extra request that
// arrives mid-sweep is remembered and replayed as soon as the sweep ends.
module dot_update_sequencer #(
    parameter int NUM_DOTS    = dot_pkg::NUM_DOTS,
    parameter int HOLD_CYCLES = dot_pkg::HOLD_CYCLES,
    parameter int WIDTH       = dot_pkg::WIDTH,
    parameter int HEIGHT      = dot_pkg::HEIGHT,
    parameter int ID_W        = $clog2(NUM_DOTS)
) (
    input logic                   clk,
    input logic                   reset,
    dot_update_sequencer_if.slave bus
);
    import dot_pkg::*;

    localparam int              HW        = $clog2(HOLD_CYCLES + 1);
    localparam logic [ID_W-1:0] LAST_IDX  = ID_W'(NUM_DOTS - 1);
    localparam logic [HW-1:0]   HOLD_LOAD = HW'(HOLD_CYCLES - 1);

    dot_state_e      state_q, state_d;
    logic [ID_W-1:0] idx_q, idx_d;
    logic [HW-1:0]   hold_q, hold_d;
    logic            pending_q, pending_d;
    logic [Y_W-1:0]  y_hold_q, y_hold_d;
    logic            se_q, se_prev_q;
    logic            dot_wren_q, dot_wren_d;
    logic            is_y_q, is_y_d;
    logic [31:0]     dot_id_q, dot_id_d;
    logic [31:0]     dot_loc_q, dot_loc_d;
    logic            busy_q;
    logic            frame_done_q, frame_done_d;
    logic            rise_s;
    logic            clr_s;
    logic [X_W-1:0]  rd_x_s;
    logic [Y_W-1:0]  rd_y_s;
    logic            rd_dirty_s;

    dot_shadow_ram #(
        .N      (NUM_DOTS),
        .IDW    (ID_W),
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT)
    ) u_shadow (
        .clk        (clk),
        .rst_n      (reset),
        .wr_en_i    (bus.procWren),
        .wr_id_i    (bus.procID),
        .wr_x_i     (bus.procX),
        .wr_y_i     (bus.procY),
        .rd_idx_i   (idx_q),
        .clr_i      (clr_s),
        .rd_x_o     (rd_x_s),
        .rd_y_o     (rd_y_s),
        .rd_dirty_o (rd_dirty_s)
    );

    assign rise_s = se_q && !se_prev_q;

    // Next-state, sweep bookkeeping and registered-output values.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        hold_d       = hold_q;
        y_hold_d     = y_hold_q;
        clr_s        = 1'b0;
        dot_wren_d   = 1'b0;
        is_y_d       = 1'b0;
        dot_id_d     = dot_id_q;
        dot_loc_d    = dot_loc_q;
        frame_done_d = 1'b0;
        if (rise_s && (state_q != ST_IDLE) && (state_q != ST_DONE)) begin
            pending_d = 1'b1;
        end else begin
            pending_d = pending_q;
        end
        case (state_q)
            ST_IDLE: begin
                if (rise_s || pending_q) begin
                    state_d   = ST_SCAN;
                    idx_d     = '0;
                    pending_d = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SCAN: begin
                if (rd_dirty_s) begin
                    clr_s      = 1'b1;
                    y_hold_d   = rd_y_s;
                    dot_id_d   = 32'(idx_q);
                    dot_loc_d  = 32'(rd_x_s);
                    dot_wren_d = 1'b1;
                    hold_d     = HOLD_LOAD;
                    state_d    = ST_SEND_X;
                end else if (idx_q == LAST_IDX) begin
                    frame_done_d = 1'b1;
                    state_d      = ST_DONE;
                end else begin
                    idx_d = idx_q + ID_W'(1);
                end
            end
            ST_SEND_X: begin
                dot_wren_d = 1'b1;
                if (hold_q == '0) begin
                    is_y_d    = 1'b1;
                    dot_loc_d = 32'(y_hold_q);
                    hold_d    = HOLD_LOAD;
                    state_d   = ST_SEND_Y;
                end else begin
                    hold_d = hold_q - HW'(1);
                end
            end
            ST_SEND_Y: begin
                if (hold_q != '0) begin
                    dot_wren_d = 1'b1;
                    is_y_d     = 1'b1;
                    hold_d     = hold_q - HW'(1);
                end else if (idx_q == LAST_IDX) begin
                    frame_done_d = 1'b1;
                    state_d      = ST_DONE;
                end else begin
                    idx_d   = idx_q + ID_W'(1);
                    state_d = ST_SCAN;
                end
            end
            ST_DONE: begin
                if (pending_q || rise_s) begin
                    pending_d = 1'b0;
                    idx_d     = '0;
                    state_d   = ST_SCAN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, edge detector and output registers; reset drops outputs at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            hold_q       <= '0;
            pending_q    <= 1'b0;
            y_hold_q     <= '0;
            se_q         <= 1'b0;
            se_prev_q    <= 1'b0;
            dot_wren_q   <= 1'b0;
            is_y_q       <= 1'b0;
            dot_id_q     <= '0;
            dot_loc_q    <= '0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            hold_q       <= hold_d;
            pending_q    <= pending_d;
            y_hold_q     <= y_hold_d;
            se_q         <= bus.screenEnd;
            se_prev_q    <= se_q;
            dot_wren_q   <= dot_wren_d;
            is_y_q       <= is_y_d;
            dot_id_q     <= dot_id_d;
            dot_loc_q    <= dot_loc_d;
            busy_q       <= (state_d != ST_IDLE);
            frame_done_q <= frame_done_d;
        end
    end

    assign bus.dotWren   = dot_wren_q;
    assign bus.is_Yloc   = is_y_q;
    assign bus.dotID     = dot_id_q;
    assign bus.dotLoc    = dot_loc_q;
    assign bus.busy      = busy_q;
    assign bus.frameDone = frame_done_q;
endmodule

// File: tb/tb_dot_update_sequencer.sv
// Scoreboard bench for dot_update_sequencer: a list-level model of the shadow
// buffer predicts the beats of each sweep; a monitor groups observed beats
// and checks them, and their hold length, against the expected queue.
module tb_dot_update_sequencer;
    import dot_pkg::*;

    localparam int ND   = NUM_DOTS;
    localparam int HOLD = HOLD_CYCLES;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dot_update_sequencer_if dif();

    dot_update_sequencer dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (dif.slave)
    );

    int total = 0;
    int bad   = 0;

    int unsigned  mx [ND];
    int unsigned  my [ND];
    bit           mdirty [ND];
    logic [64:0]  exp_q [$];

    logic [64:0] run_key;
    logic [64:0] cur_key;
    logic [64:0] exp_key;
    int          run_len = 0;
    bit          run_act = 1'b0;
    bit          fd_prev = 1'b0;

    function automatic int unsigned clampv(int unsigned v, int unsigned lim);
        return (v >= lim) ? lim - 1 : v;
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    task automatic model_clear();
        exp_q.delete();
        for (int i = 0; i < ND; i++) begin
            mx[i] = 0; my[i] = 0; mdirty[i] = 1'b0;
        end
    endtask

    task automatic proc_write(int unsigned id, int unsigned x, int unsigned y);
        dif.procWren = 1'b1; dif.procID = id; dif.procX = x; dif.procY = y;
        @(negedge clk);
        dif.procWren = 1'b0;
        if (id < ND) begin
            mx[id] = clampv(x, WIDTH);
            my[id] = clampv(y, HEIGHT);
            mdirty[id] = 1'b1;
        end
    endtask

    task automatic start_sweep();
        for (int i = 0; i < ND; i++) begin
            if (mdirty[i]) begin
                exp_q.push_back({1'b0, 32'(i), 32'(mx[i])});
                exp_q.push_back({1'b1, 32'(i), 32'(my[i])});
                mdirty[i] = 1'b0;
            end
        end
        dif.screenEnd = 1'b1;
        @(negedge clk);
        dif.screenEnd = 1'b0;
    endtask

    task automatic wait_frames(int n, string name);
        int fd = 0;
        for (int k = 0; k < 1000 && fd < n; k++) begin
            @(negedge clk);
            if (dif.frameDone === 1'b1) fd++;
        end
        check({name, "_frameDone"}, 64'(fd), 64'(n));
        repeat (2) @(negedge clk);
        check({name, "_beats_left"}, 64'(exp_q.size()), 64'd0);
        check({name, "_busy_idle"}, 64'(dif.busy), 64'd0);
    endtask

    task automatic check_outputs_zero(string name);
        check({name, "_dotWren"},   64'(dif.dotWren),   64'd0);
        check({name, "_is_Yloc"},   64'(dif.is_Yloc),   64'd0);
        check({name, "_dotID"},     64'(dif.dotID),     64'd0);
        check({name, "_dotLoc"},    64'(dif.dotLoc),    64'd0);
        check({name, "_busy"},      64'(dif.busy),      64'd0);
        check({name, "_frameDone"}, 64'(dif.frameDone), 64'd0);
    endtask

    // Monitor: group constant beats, compare each finished beat with the queue.
    always @(negedge clk) begin
        if (!rst_n) begin
            run_act = 1'b0;
            fd_prev = 1'b0;
        end else begin
            if (dif.frameDone === 1'b1) begin
                total++;
                if (fd_prev) begin
                    bad++;
                    $display("FAIL frameDone_width: got 2+ cycles expected 1");
                end
            end
            fd_prev = (dif.frameDone === 1'b1);
            cur_key = {dif.is_Yloc, dif.dotID, dif.dotLoc};
            if (run_act && ((dif.dotWren !== 1'b1) || (cur_key !== run_key))) begin
                run_act = 1'b0;
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_beat: got y=%0d id=%0d loc=%0d expected no beat",
                             run_key[64], run_key[63:32], run_key[31:0]);
                end else begin
                    exp_key = exp_q.pop_front();
                    if (exp_key !== run_key) begin
                        bad++;
                        $display("FAIL beat: got y=%0d id=%0d loc=%0d expected y=%0d id=%0d loc=%0d",
                                 run_key[64], run_key[63:32], run_key[31:0],
                                 exp_key[64], exp_key[63:32], exp_key[31:0]);
                    end
                end
                check("beat_hold_len", 64'(run_len), 64'(HOLD));
            end
            if (dif.dotWren === 1'b1) begin
                if (!run_act) begin
                    run_act = 1'b1;
                    run_key = cur_key;
                    run_len = 1;
                end else begin
                    run_len++;
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int fd;
        bit busy_low;
        int unsigned old_x;
        int unsigned old_y;

        dif.procWren = 1'b0; dif.procID = '0; dif.procX = '0; dif.procY = '0;
        dif.screenEnd = 1'b0;
        model_clear();
        repeat (3) @(negedge clk);
        check_outputs_zero("reset_held");
        rst_n = 1'b1;
        @(negedge clk);
        check_outputs_zero("reset_release");

        // Single dirty dot.
        proc_write(3, 100, 200);
        start_sweep();
        wait_frames(1, "t1");

        // Empty sweep: no beats, frameDone NUM_DOTS+2 cycles after the rise.
        dif.screenEnd = 1'b1;
        for (k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (k == 1) dif.screenEnd = 1'b0;
            if (dif.frameDone === 1'b1) break;
        end
        check("t5_latency", 64'(k), 64'(ND + 2));
        repeat (2) @(negedge clk);
        check("t5_beats_left", 64'(exp_q.size()), 64'd0);

        // All dots, plus a second rise mid-sweep that yields an empty sweep.
        for (int i = 0; i < ND; i++) proc_write(i, $urandom_range(0, 639), $urandom_range(0, 479));
        start_sweep();
        busy_low = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (dif.busy !== 1'b1) busy_low = 1'b1;
        end
        dif.screenEnd = 1'b1;
        @(negedge clk);
        dif.screenEnd = 1'b0;
        fd = 0;
        for (int j = 0; j < 1000 && fd < 2; j++) begin
            @(negedge clk);
            if (dif.busy !== 1'b1) busy_low = 1'b1;
            if (dif.frameDone === 1'b1) fd++;
        end
        check("t2_frameDone_count", 64'(fd), 64'd2);
        check("t2_busy_dropped", 64'(busy_low), 64'd0);
        repeat (2) @(negedge clk);
        check("t2_beats_left", 64'(exp_q.size()), 64'd0);
        check("t2_busy_idle", 64'(dif.busy), 64'd0);

        // Clamping and out-of-range ID.
        proc_write(5, 700, 600);
        start_sweep();
        wait_frames(1, "t3_clamp");
        proc_write(12, 33, 44);
        start_sweep();
        wait_frames(1, "t3_bad_id");

        // Write on the same cycle SCAN latches dot 2.
        old_x = $urandom_range(0, 639);
        old_y = $urandom_range(0, 479);
        proc_write(2, old_x, old_y);
        start_sweep();
        repeat (3) @(negedge clk);
        proc_write(2, old_x ^ 32'd1, old_y ^ 32'd1);
        wait_frames(1, "t4_old");
        start_sweep();
        wait_frames(1, "t4_new");

        // Randomised write batches between sweeps.
        for (int r = 0; r < 6; r++) begin
            int n;
            n = $urandom_range(0, 8);
            for (int j = 0; j < n; j++)
                proc_write($urandom_range(0, 11), $urandom_range(0, 1100), $urandom_range(0, 800));
            repeat ($urandom_range(0, 3)) @(negedge clk);
            start_sweep();
            wait_frames(1, "rand");
        end

        // Reset during the X beat of dot 4.
        proc_write(4, 321, 123);
        start_sweep();
        for (k = 0; k < 100; k++) begin
            @(negedge clk);
            if (dif.dotWren === 1'b1) break;
        end
        check("t6_reach_send_x", 64'(dif.dotWren), 64'd1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_outputs_zero("t6_mid_reset");
        model_clear();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        start_sweep();
        wait_frames(1, "t6_after");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
